// File: rtl/multiword_add_pkg.sv
// Shared types and helpers for the multiword add/subtract sequencer.
// Holds the FSM state encoding and the counter-width helper.
package multiword_add_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/multiword_add_seq_chunk_adder.sv
// Combinational N-bit ripple adder shared by all chunk steps.
// Ports: a_i, b_i (N), c_i carry-in; sum_o (N), c_o carry-out.
module chunk_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] sum_o,
   output logic         c_o
);

   logic [N:0] c;

   always_comb begin
      c[0] = c_i;
      for (int i = 0; i < N; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]   = (a_i[i] & b_i[i]) |
                    (c[i] & (a_i[i] ^ b_i[i]));
      end
      c_o = c[N];
   end

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/sub over M cycles through one N-bit chunk adder.
// Ports: clk_i, rst_i, start_i, a_i, b_i, c_i, sub_i; busy_o, done_o, res_o.
module multiword_add_seq
   import multiword_add_pkg::*;
#(
   parameter  int N = 4,
   parameter  int M = 4,
   localparam int W = N * M
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         start_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         c_i,
   input  logic         sub_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [W:0]   res_o
);

   localparam int CW = clog2_min1(M);
   localparam logic [CW-1:0] LAST = CW'(M - 1);

   state_e state_q;
   state_e state_d;

   logic [CW-1:0] cnt_q;
   logic [W-1:0]  op_a_q;
   logic [W-1:0]  op_b_q;
   logic [W-1:0]  acc_q;
   logic [W-1:0]  acc_d;
   logic          carry_q;
   logic          busy_q;
   logic          done_q;
   logic [W:0]    res_q;

   logic [N-1:0]  ch_a;
   logic [N-1:0]  ch_b;
   logic [N-1:0]  ch_sum;
   logic          ch_co;

   logic          accept;
   logic          step;
   logic          last;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start_i) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      step   = 1'b0;
      last   = 1'b0;
      unique case (1'b1)
         (state_q == IDLE): accept = start_i;
         (state_q == RUN): begin
            step = 1'b1;
            last = (cnt_q == LAST);
         end
         (state_q == DONE): ;
         default: ;
      endcase
   end

   assign ch_a = op_a_q[cnt_q*N +: N];
   assign ch_b = op_b_q[cnt_q*N +: N];

   chunk_adder #(
      .N(N)
   ) u_chunk (
      .a_i   (ch_a),
      .b_i   (ch_b),
      .c_i   (carry_q),
      .sum_o (ch_sum),
      .c_o   (ch_co)
   );

   // Accumulator with the current chunk merged in, so the
   // final step can load res_q in the same edge.
   always_comb begin
      acc_d = acc_q;
      acc_d[cnt_q*N +: N] = ch_sum;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         op_a_q  <= '0;
         op_b_q  <= '0;
         acc_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            op_a_q  <= a_i;
            // Subtract as A + ~B + 1.
            op_b_q  <= sub_i ? ~b_i : b_i;
            carry_q <= sub_i ? 1'b1 : c_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
         end
         if (step) begin
            acc_q   <= acc_d;
            carry_q <= ch_co;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
               res_q  <= {ch_co, acc_d};
               done_q <= 1'b1;
            end
         end
         if (state_q == DONE) busy_q <= 1'b0;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign res_o  = res_q;

endmodule

// File: doc/multiword_add_seq.md
# multiword_add_seq

Sequencer that adds two W = N·M-bit operands by time-multiplexing one N-bit chunk adder over M clock cycles. The carry is chained through a register between cycles. It provides wide add and subtract without a W-bit ripple chain. It sits between a requesting datapath (start/done handshake) and the team's chunk-level ripple adder, and owns the operand slicing, carry sequencing and result assembly.

## Interface
Parameters:
- N, default 4: chunk width in bits, and the width of the shared adder.
- M, default 4: number of chunks, ≥ 2.
- W, derived as N*M: operand width. Not overridable.

Ports:
- clk_i, input, 1: single clock, rising edge.
- rst_i, input, 1: reset, synchronous, active-high.
- start_i, input, 1: request. Sampled only in IDLE.
- a_i, input, W: operand A. Sampled with start_i.
- b_i, input, W: operand B. Sampled with start_i.
- c_i, input, 1: carry-in. Sampled with start_i. Ignored when sub_i = 1.
- sub_i, input, 1: 1 = compute A − B. Sampled with start_i.
- busy_o, output, 1: high from start acceptance until return to IDLE.
- done_o, output, 1: one-cycle pulse when res_o is updated.
- res_o, output, W+1: registered result. Bit W is carry-out (add) or not-borrow (sub).

## Operation
- The FSM has three states: IDLE, RUN, DONE.
- IDLE, on start_i = 1:
  - Latch a_i into op_a.
  - Latch b_i into op_b, or ~b_i if sub_i = 1.
  - Load carry_q with c_i, or 1 if sub_i = 1.
  - Set cnt = 0 and move to RUN.
- IDLE, on start_i = 0: stay in IDLE.
- RUN, each cycle:
  - The chunk adder gets op_a[cnt·N +: N], op_b[cnt·N +: N] and carry_q.
  - The sum is written into acc[cnt·N +: N] and the carry-out into carry_q.
  - cnt increments.
  - When cnt = M−1, the final chunk is processed and the FSM moves to DONE.
- DONE transition:
  - res_o is loaded with {carry-out, acc including the final chunk}.
  - done_o = 1 for exactly this one cycle.
  - The next edge returns the FSM to IDLE.
- start_i is ignored in RUN and DONE. There is no queueing and no error flag.
- res_o holds its value until the next DONE. Intermediate chunk sums are never visible on res_o.
- Arithmetic is modular:
  - Add: res_o = A + B + c_i, using W+1 bits.
  - Sub: res_o[W-1:0] = (A − B) mod 2^W. res_o[W] = 1 when A ≥ B (unsigned), 0 on borrow.
- Reset:
  - Any cycle with rst_i = 1 forces IDLE and clears busy_o, done_o, res_o, cnt, carry_q, acc, op_a and op_b to 0.
  - Reset mid-RUN or in DONE aborts the operation. No done_o pulse is produced and the previous res_o is cleared.
  - rst_i takes priority over start_i in the same cycle.

## Timing
- Edge 0 samples start_i = 1. From then: state = RUN, busy_o = 1.
- Edges 1..M each process chunk 0..M−1. Edge M leaves state = DONE, done_o = 1, res_o valid.
- Edge M+1 leaves state = IDLE, done_o = 0, busy_o = 0.
- Latency from start to done_o is M edges. Throughput is one operation per M+2 cycles. The earliest next accept is at edge M+2.
- busy_o, done_o and res_o are all registered. There is no combinational path from inputs to outputs.
- The only combinational path is the N-bit chunk adder inside one cycle. The critical path scales with N, not W.

## Structure
- Package multiword_add_pkg holds:
  - typedef enum logic [1:0] state_e {IDLE, RUN, DONE};
  - function clog2_min1(M), used for cnt width, minimum 1 bit.
- Sub-module chunk_adder is a combinational N-bit ripple adder:
  - Inputs a_i[N-1:0], b_i[N-1:0], c_i.
  - Outputs sum_o[N-1:0], c_o.
  - Instantiated exactly once.
- The top level contains the FSM, cnt, operand registers, acc, carry_q and the output registers.

## Test plan
Defaults N = 4, M = 4 (W = 16):
- Carry ripple across all chunks: a = 0xFFFF, b = 0x0001, c_i = 0, sub_i = 0 → done_o at edge 4 after start, res_o = 0x1_0000. busy_o high for 5 cycles.
- Carry-in: a = 0x1234, b = 0x4321, c_i = 1 → res_o = 0x0_5556. done_o high for exactly 1 cycle.
- Subtract with borrow: a = 0x0005, b = 0x0007, sub_i = 1, c_i = 1 → res_o = 0x0_FFFE (c_i ignored).
- Subtract without borrow: a = 0x0007, b = 0x0005, sub_i = 1 → res_o = 0x1_0002.
- Busy rejection: start_i held high with new operands during RUN and DONE → the first result is unchanged. The next accept happens at edge M+2 with the operands present then.
- Reset mid-RUN: assert rst_i at edge 2 after start → next cycle has busy_o = 0, res_o = 0, and no done_o pulse. A subsequent start completes normally.
